// File: rtl/btb_pkg.sv
// Shared types, constants and PC field helpers for the set-associative BTB.
package btb_pkg;

  localparam int unsigned BTB_SET_ADDR_LEN = 6;
  localparam int unsigned BTB_TAG_ADDR_LEN = 8;
  localparam int unsigned BTB_WAYS         = 2;
  localparam int unsigned BTB_CNT_BITS     = 2;

  typedef struct packed {
    logic                        valid;
    logic [BTB_TAG_ADDR_LEN-1:0] tag;
    logic [31:0]                 target;
    logic [BTB_CNT_BITS-1:0]     cnt;
  } btb_entry_t;

  // Weakly-taken encoding: MSB set, all lower bits clear.
  function automatic logic [31:0] cnt_weak_taken(input int unsigned bits);
    return 32'(1) << (bits - 1);
  endfunction

  function automatic logic [31:0] cnt_max(input int unsigned bits);
    return (bits >= 32) ? 32'hFFFF_FFFF : (32'(1) << bits) - 32'(1);
  endfunction

  // Set index sits just above the byte offset; tag sits just above the set.
  function automatic logic [31:0] pc_set(input logic [31:0] pc, input int unsigned set_len);
    return (pc >> 2) & ((32'(1) << set_len) - 32'(1));
  endfunction

  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned set_len,
                                         input int unsigned tag_len);
    return (pc >> (set_len + 2)) & ((32'(1) << tag_len) - 32'(1));
  endfunction

endpackage

// File: rtl/btb_assoc_sat_ctr.sv
// Saturating up/down direction counter used on the BTB update path.
module sat_ctr
  import btb_pkg::*;
#(
  parameter int unsigned CNT_BITS = 2
) (
  input  logic [CNT_BITS-1:0] cur,
  input  logic                inc,
  input  logic                dec,
  output logic [CNT_BITS-1:0] nxt
);

  localparam logic [CNT_BITS-1:0] MAX = CNT_BITS'(cnt_max(CNT_BITS));

  always_comb begin
    nxt = cur;
    if (inc && !dec) begin
      if (cur != MAX) nxt = cur + CNT_BITS'(1);
    end else if (dec && !inc) begin
      if (cur != '0) nxt = cur - CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: combinational IF-stage prediction,
// registered EX-stage updates with round-robin victim selection and flush.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int unsigned SET_ADDR_LEN = 6,
  parameter int unsigned TAG_ADDR_LEN = 8,
  parameter int unsigned WAYS         = 2,
  parameter int unsigned CNT_BITS     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_pc,
  output logic [31:0] pred_pc,
  output logic        pred_take,
  output logic        pred_hit,
  input  logic        wr_en,
  input  logic [31:0] wr_pc,
  input  logic [31:0] wr_target,
  input  logic        taken,
  input  logic        flush
);

  localparam int unsigned SETS  = 1 << SET_ADDR_LEN;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CNT_BITS-1:0] CNT_WT = CNT_BITS'(cnt_weak_taken(CNT_BITS));

  logic                    valid_q  [SETS][WAYS];
  logic                    valid_d  [SETS][WAYS];
  logic [TAG_ADDR_LEN-1:0] tag_q    [SETS][WAYS];
  logic [TAG_ADDR_LEN-1:0] tag_d    [SETS][WAYS];
  logic [31:0]             target_q [SETS][WAYS];
  logic [31:0]             target_d [SETS][WAYS];
  logic [CNT_BITS-1:0]     cnt_q    [SETS][WAYS];
  logic [CNT_BITS-1:0]     cnt_d    [SETS][WAYS];
  logic [WAY_W-1:0]        vptr_q   [SETS];
  logic [WAY_W-1:0]        vptr_d   [SETS];

  logic [SET_ADDR_LEN-1:0] rd_set, wr_set;
  logic [TAG_ADDR_LEN-1:0] rd_tag, wr_tag;
  logic                    rd_hit, wr_hit, wr_has_inv;
  logic [WAY_W-1:0]        rd_way, wr_way, wr_inv_way, victim;
  logic [CNT_BITS-1:0]     cnt_nxt;

  assign rd_set = SET_ADDR_LEN'(pc_set(rd_pc, SET_ADDR_LEN));
  assign rd_tag = TAG_ADDR_LEN'(pc_tag(rd_pc, SET_ADDR_LEN, TAG_ADDR_LEN));
  assign wr_set = SET_ADDR_LEN'(pc_set(wr_pc, SET_ADDR_LEN));
  assign wr_tag = TAG_ADDR_LEN'(pc_tag(wr_pc, SET_ADDR_LEN, TAG_ADDR_LEN));

  // Read lookup; lowest-index matching way wins should duplicates ever exist.
  always_comb begin
    rd_hit = 1'b0;
    rd_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!rd_hit && valid_q[rd_set][WAY_W'(w)] && tag_q[rd_set][WAY_W'(w)] == rd_tag) begin
        rd_hit = 1'b1;
        rd_way = WAY_W'(w);
      end
    end
  end

  assign pred_hit  = rd_hit;
  assign pred_take = rd_hit && cnt_q[rd_set][rd_way][CNT_BITS-1];
  assign pred_pc   = pred_take ? target_q[rd_set][rd_way] : rd_pc + 32'd4;

  // Update lookup: hitting way plus lowest invalid way for allocation.
  always_comb begin
    wr_hit     = 1'b0;
    wr_way     = '0;
    wr_has_inv = 1'b0;
    wr_inv_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!wr_hit && valid_q[wr_set][WAY_W'(w)] && tag_q[wr_set][WAY_W'(w)] == wr_tag) begin
        wr_hit = 1'b1;
        wr_way = WAY_W'(w);
      end
      if (!wr_has_inv && !valid_q[wr_set][WAY_W'(w)]) begin
        wr_has_inv = 1'b1;
        wr_inv_way = WAY_W'(w);
      end
    end
    victim = wr_has_inv ? wr_inv_way : vptr_q[wr_set];
  end

  sat_ctr #(.CNT_BITS(CNT_BITS)) u_sat_ctr (
    .cur (cnt_q[wr_set][wr_way]),
    .inc (taken),
    .dec (!taken),
    .nxt (cnt_nxt)
  );

  // Next-state: flush beats update; not-taken misses never allocate.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    vptr_d   = vptr_q;
    if (flush) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        vptr_d[s] = '0;
        for (int unsigned w = 0; w < WAYS; w++) valid_d[s][w] = 1'b0;
      end
    end else if (wr_en) begin
      if (wr_hit) begin
        cnt_d[wr_set][wr_way] = cnt_nxt;
        if (taken) target_d[wr_set][wr_way] = wr_target;
      end else if (taken) begin
        valid_d[wr_set][victim]  = 1'b1;
        tag_d[wr_set][victim]    = wr_tag;
        target_d[wr_set][victim] = wr_target;
        cnt_d[wr_set][victim]    = CNT_WT;
        vptr_d[wr_set]           = WAY_W'((32'(victim) + 32'd1) % WAYS);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        vptr_q[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_q[s][w]  <= 1'b0;
          tag_q[s][w]    <= '0;
          target_q[s][w] <= '0;
          cnt_q[s][w]    <= '0;
        end
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      vptr_q   <= vptr_d;
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed vector bench for btb_assoc with default parameters.
module tb_btb_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd_pc, pred_pc, wr_pc, wr_target;
  logic        pred_take, pred_hit, wr_en, taken, flush;

  int vectors = 0;
  int miscompares = 0;

  btb_assoc dut (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (rd_pc),
    .pred_pc   (pred_pc),
    .pred_take (pred_take),
    .pred_hit  (pred_hit),
    .wr_en     (wr_en),
    .wr_pc     (wr_pc),
    .wr_target (wr_target),
    .taken     (taken),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [31:0] wr_pc;
    logic [31:0] wr_target;
    logic        taken;
    logic [31:0] rd_pc;
    logic        exp_hit;
    logic        exp_take;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [31:0] wp, input logic [31:0] wt,
                              input logic tk, input logic [31:0] rp, input logic eh,
                              input logic et, input logic [31:0] ep);
    vec_t v;
    v.wr_en = we; v.wr_pc = wp; v.wr_target = wt; v.taken = tk;
    v.rd_pc = rp; v.exp_hit = eh; v.exp_take = et; v.exp_pc = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic eh, input logic et, input logic [31:0] ep);
    vectors++;
    if (pred_hit !== eh || pred_take !== et || pred_pc !== ep) begin
      miscompares++;
      $display("FAIL %s: got hit=%b take=%b pc=%08h, expected hit=%b take=%b pc=%08h",
               nm, pred_hit, pred_take, pred_pc, eh, et, ep);
    end
  endtask

  // Two ways of one set must never hold the same valid tag.
  always @(negedge clk) begin
    if (!rst) begin
      for (int s = 0; s < 64; s++) begin
        if (dut.valid_q[s][0] && dut.valid_q[s][1] && dut.tag_q[s][0] == dut.tag_q[s][1]) begin
          miscompares++;
          $display("FAIL dup_tag: set %0d holds tag %02h in both ways", s, dut.tag_q[s][0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_pc = '0; wr_target = '0; taken = 1'b0; flush = 1'b0;
    rd_pc = 32'h100;

    //          wr_en  wr_pc         wr_target     tk    rd_pc         hit   take  pred_pc
    vecs.push_back(mk(1'b0, 32'h0,      32'h0,      1'b0, 32'h100,      1'b0, 1'b0, 32'h104));
    vecs.push_back(mk(1'b1, 32'h100,    32'h200,    1'b1, 32'h100,      1'b0, 1'b0, 32'h104));
    vecs.push_back(mk(1'b1, 32'h100,    32'hBAD0,   1'b0, 32'h100,      1'b1, 1'b1, 32'h200));
    vecs.push_back(mk(1'b1, 32'h100,    32'hBAD0,   1'b0, 32'h100,      1'b1, 1'b0, 32'h104));
    vecs.push_back(mk(1'b1, 32'h100,    32'hBAD0,   1'b0, 32'h100,      1'b1, 1'b0, 32'h104));
    vecs.push_back(mk(1'b1, 32'h100,    32'h500,    1'b1, 32'h100,      1'b1, 1'b0, 32'h104));
    vecs.push_back(mk(1'b1, 32'h100,    32'h500,    1'b1, 32'h100,      1'b1, 1'b0, 32'h104));
    vecs.push_back(mk(1'b1, 32'h100,    32'h500,    1'b1, 32'h100,      1'b1, 1'b1, 32'h500));
    vecs.push_back(mk(1'b1, 32'h100,    32'h500,    1'b1, 32'h100,      1'b1, 1'b1, 32'h500));
    vecs.push_back(mk(1'b1, 32'h100,    32'hBAD0,   1'b0, 32'h100,      1'b1, 1'b1, 32'h500));
    vecs.push_back(mk(1'b0, 32'h0,      32'h0,      1'b0, 32'h100,      1'b1, 1'b1, 32'h500));
    vecs.push_back(mk(1'b1, 32'h200,    32'h600,    1'b1, 32'h200,      1'b0, 1'b0, 32'h204));
    vecs.push_back(mk(1'b1, 32'h300,    32'h700,    1'b1, 32'h200,      1'b1, 1'b1, 32'h600));
    vecs.push_back(mk(1'b0, 32'h0,      32'h0,      1'b0, 32'h100,      1'b0, 1'b0, 32'h104));
    vecs.push_back(mk(1'b0, 32'h0,      32'h0,      1'b0, 32'h200,      1'b1, 1'b1, 32'h600));
    vecs.push_back(mk(1'b1, 32'h900,    32'hA00,    1'b1, 32'h300,      1'b1, 1'b1, 32'h700));
    vecs.push_back(mk(1'b0, 32'h0,      32'h0,      1'b0, 32'h200,      1'b0, 1'b0, 32'h204));
    vecs.push_back(mk(1'b0, 32'h0,      32'h0,      1'b0, 32'h300,      1'b1, 1'b1, 32'h700));
    vecs.push_back(mk(1'b0, 32'h0,      32'h0,      1'b0, 32'h900,      1'b1, 1'b1, 32'hA00));
    vecs.push_back(mk(1'b1, 32'h1004,   32'h2000,   1'b0, 32'h1004,     1'b0, 1'b0, 32'h1008));
    vecs.push_back(mk(1'b0, 32'h0,      32'h0,      1'b0, 32'h1004,     1'b0, 1'b0, 32'h1008));
    vecs.push_back(mk(1'b0, 32'h0,      32'h0,      1'b0, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 32'h0,      32'h0,      1'b0, 32'h10300,    1'b1, 1'b1, 32'h700));
    vecs.push_back(mk(1'b1, 32'h104,    32'h44,     1'b1, 32'h104,      1'b0, 1'b0, 32'h108));
    vecs.push_back(mk(1'b0, 32'h0,      32'h0,      1'b0, 32'h104,      1'b1, 1'b1, 32'h44));
    vecs.push_back(mk(1'b0, 32'h0,      32'h0,      1'b0, 32'h900,      1'b1, 1'b1, 32'hA00));

    #3 chk("reset_state", 1'b0, 1'b0, 32'h104);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_reset", 1'b0, 1'b0, 32'h104);

    foreach (vecs[i]) begin
      @(negedge clk);
      wr_en = vecs[i].wr_en; wr_pc = vecs[i].wr_pc; wr_target = vecs[i].wr_target;
      taken = vecs[i].taken; rd_pc = vecs[i].rd_pc;
      #1 chk($sformatf("vec%0d", i), vecs[i].exp_hit, vecs[i].exp_take, vecs[i].exp_pc);
    end

    // Flush alongside an allocating update: everything misses afterwards.
    @(negedge clk);
    flush = 1'b1; wr_en = 1'b1; wr_pc = 32'h400; wr_target = 32'h800; taken = 1'b1;
    rd_pc = 32'h300;
    #1 chk("flush_pre", 1'b1, 1'b1, 32'h700);
    @(negedge clk);
    flush = 1'b0; wr_en = 1'b0;
    rd_pc = 32'h300; #1 chk("flush_300", 1'b0, 1'b0, 32'h304);
    rd_pc = 32'h900; #1 chk("flush_900", 1'b0, 1'b0, 32'h904);
    rd_pc = 32'h104; #1 chk("flush_104", 1'b0, 1'b0, 32'h108);
    rd_pc = 32'h400; #1 chk("flush_400", 1'b0, 1'b0, 32'h404);

    // Refill after flush, then async reset mid-cycle with an update in flight.
    @(negedge clk);
    wr_en = 1'b1; wr_pc = 32'h100; wr_target = 32'h200; taken = 1'b1; rd_pc = 32'h100;
    @(negedge clk);
    wr_en = 1'b0;
    #1 chk("refill_100", 1'b1, 1'b1, 32'h200);
    wr_en = 1'b1; wr_pc = 32'h200; wr_target = 32'h300; taken = 1'b1;
    #1 rst = 1'b1;
    #1 chk("async_rst", 1'b0, 1'b0, 32'h104);
    @(negedge clk);
    wr_en = 1'b0; rst = 1'b0;
    #1 chk("rst_100", 1'b0, 1'b0, 32'h104);
    rd_pc = 32'h200; #1 chk("rst_lost_wr", 1'b0, 1'b0, 32'h204);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Parametrised set-associative branch target buffer for the IF stage; generational successor to the direct-mapped single-bit BTB.
- Adds N-way associativity, per-entry saturating direction counters, round-robin victim selection per set, a full fall-through next PC, and a one-cycle flush.
- Prediction is combinational from rd_pc in the IF stage; updates come from EX branch resolution and are registered.

Parameters:
- SET_ADDR_LEN, 6, index bits; sets = 2**SET_ADDR_LEN.
- TAG_ADDR_LEN, 8, stored tag bits; PC bits above the tag are ignored (aliasing is accepted).
- WAYS, 2, associativity; power of two, >=1; WAYS=1 gives direct-mapped behaviour.
- CNT_BITS, 2, direction counter width, >=1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rd_pc  in  32  IF-stage fetch PC
- pred_pc  out  32  predicted next PC
- pred_take  out  1  predicted taken
- pred_hit  out  1  rd_pc tag matched a valid entry
- wr_en  in  1  update strobe (resolved branch in EX)
- wr_pc  in  32  PC of resolved branch
- wr_target  in  32  resolved branch target
- taken  in  1  resolved direction
- flush  in  1  invalidate all entries

Behaviour:
- Address split:
  - pc[1:0] is ignored.
  - set = pc[SET_ADDR_LEN+1:2].
  - tag = pc[SET_ADDR_LEN+TAG_ADDR_LEN+1:SET_ADDR_LEN+2].
- Entry fields: valid, tag, target[31:0], cnt[CNT_BITS-1:0]. Per-set state: victim pointer, log2(WAYS) bits (0 bits when WAYS=1).
- Read path (combinational, 0-cycle):
  - pred_hit = any way in set(rd_pc) with valid && tag match.
  - pred_take = pred_hit && cnt MSB of the hitting way.
  - pred_pc = pred_take ? hitting target : rd_pc+4. The +4 wraps mod 2**32.
- Multiple ways matching cannot occur by construction. If it does, the lowest-index way wins; the bench asserts it never happens.
- Update (registered; visible to reads the cycle after the wr_en edge). For set s = set(wr_pc), tag t = tag(wr_pc):
  - Hit, taken=1: cnt saturating-increments (max all-ones); target <= wr_target.
  - Hit, taken=0: cnt saturating-decrements (min 0); target is unchanged; the entry stays valid.
  - Miss, taken=1: allocate. Victim is the lowest-index invalid way if any exists, else way victim_ptr[s]. Write valid=1, tag=t, target=wr_target, cnt=WEAK_TAKEN (10...0). Then victim_ptr[s] <= victim+1 mod WAYS.
  - Miss, taken=0: no change (no allocation of not-taken branches).
- Victim pointer advances only on allocation, never on hits.
- Same-cycle read and write to the same set or PC: the read returns pre-update contents. There is no bypass.
- Flush:
  - flush=1 clears every valid bit and every victim_ptr at the next edge.
  - flush has priority over wr_en; a concurrent update is dropped.
  - Tags, targets and counters are not cleared.
- Reset (async, any time including mid-update):
  - All valid=0, cnt=0, tag=0, target=0, victim_ptr=0.
  - Outputs while in reset: pred_hit=0, pred_take=0, pred_pc=rd_pc+4.
  - An in-flight wr_en is lost.
- No stall or handshake: wr_en is a single-cycle strobe, and every cycle with wr_en=1 is one update.

Decomposition:
- Shared package btb_pkg holds:
  - CNT_WEAK_TAKEN and CNT_MAX constant functions of CNT_BITS.
  - The btb_entry_t struct (valid, tag, target, cnt), parametrised through package localparams matching the defaults.
  - A function for the pc field split.
- One sub-module: sat_ctr (CNT_BITS parameter; inputs cur, inc, dec; output nxt), instantiated once on the update path.
- Storage is flat arrays [sets][WAYS] with async reset in the top level.

Test Plan:
- Defaults (SET=6, TAG=8, WAYS=2); PC 0x100 maps to set0/tag1, 0x200 to set0/tag2, 0x300 to set0/tag3.
- Post-reset, rd_pc=0x100 -> pred_hit=0, pred_take=0, pred_pc=0x104.
- wr_en, wr_pc=0x100, taken=1, wr_target=0x200 -> next cycle rd_pc=0x100 gives hit=1, take=1, pred_pc=0x200.
- Two taken=0 updates on 0x100 -> after the first, cnt=01, take=0, pred_pc=0x104, hit=1. After the second, cnt=00 and stays 00 on a third.
- Allocate taken 0x100, 0x200, then 0x300 -> 0x300 evicts way0 (0x100). rd 0x100 misses; 0x200 hits with target; 0x300 hits. victim_ptr[0]=1.
- Same-cycle wr_en on 0x100 (taken) with rd_pc=0x100 on an empty BTB -> that cycle hit=0; next cycle hit=1.
- flush=1 together with wr_en allocating 0x400 -> next cycle every prior PC misses and 0x400 misses. Async rst pulse mid-sequence -> outputs drop to miss immediately, without waiting for a clock edge.
